ch_readout_sequencer: RTL and testbench
=======================================

Name: ch_readout_sequencer

Overview:
- Chip-level scheduler for the slow readout path of the per-channel digital blocks.
- On a single readout request it walks every enabled channel and every timestamp/count register in a fixed order. For each word it drives the shared INST_READOUT / SELECT_REG controls and selects the channel.
- Deserializes that channel's CNT_SER stream into a parallel word and hands each word to the SPI output buffer via a valid/ready handshake.
- Sits between the SPI register file and the bank of channel digital blocks.

Parameters:
- NUM_CH, 8, number of channel digital blocks sharing the readout controls.
- NUM_REG, 6, number of SELECT_REG codes scanned per channel (0..NUM_REG-1).
- REG_BITS, 10, bits shifted per word; shorter registers are zero-padded MSB-side by the channel.

Ports:
- SPI_CLK  in  1  readout clock (40 MHz); all state on rising edge.
- RSTB  in  1  asynchronous, active-low reset.
- READOUT_REQ  in  1  single-cycle start pulse from SPI command decode.
- ABORT  in  1  synchronous abort; returns to IDLE.
- CH_MASK  in  NUM_CH  1 = channel included in scan; sampled at request.
- CNT_SER_IN  in  NUM_CH  per-channel serial readout bits (CNT_SER of each channel).
- DATA_READY  in  1  downstream buffer accepts word.
- INST_READOUT  out  1  readout strobe broadcast to all channels.
- SELECT_REG  out  3  register select broadcast to all channels.
- CH_SEL  out  $clog2(NUM_CH)  index of channel being read.
- DATA_OUT  out  REG_BITS  deserialized word.
- DATA_CH  out  $clog2(NUM_CH)  channel tag of DATA_OUT.
- DATA_REG  out  3  register tag of DATA_OUT.
- DATA_VALID  out  1  DATA_OUT/DATA_CH/DATA_REG valid.
- BUSY  out  1  high from first cycle after accepted request until DONE.
- DONE  out  1  one-cycle pulse at end of scan or abort.

Behaviour:
- Reset (RSTB low, async): state IDLE; all outputs 0; latched mask cleared; counters 0.
- States: IDLE, ARM, SHIFT, EMIT, NEXT, FIN.
- IDLE:
  - READOUT_REQ=1 latches CH_MASK into mask_q and sets ch to the lowest set bit and reg=0.
  - If mask is all-zero, go to FIN (DONE next cycle, no data); otherwise go to ARM.
  - READOUT_REQ while not IDLE is ignored.
- ARM (1 cycle): INST_READOUT=1, SELECT_REG=reg, CH_SEL=ch. Shift register cleared; bit counter=0.
- SHIFT (REG_BITS cycles):
  - INST_READOUT stays 1; SELECT_REG and CH_SEL are held stable.
  - Each cycle: shreg <= {shreg[REG_BITS-2:0], CNT_SER_IN[ch]} (MSB first).
  - After REG_BITS captures, go to EMIT.
- EMIT:
  - INST_READOUT=0, so the channel sees a falling edge and reloads on the next ARM.
  - DATA_VALID=1; DATA_OUT=shreg, DATA_CH=ch, DATA_REG=reg.
  - Outputs are held stable while DATA_READY=0 (no timeout).
  - DATA_VALID&DATA_READY moves to NEXT; DATA_VALID drops the following cycle.
- NEXT (1 cycle, combinational advance):
  - If reg<NUM_REG-1: reg++, go to ARM.
  - Else reg=0 and ch = next set bit of mask_q above ch; if one exists, go to ARM, else go to FIN.
- FIN: DONE=1 for 1 cycle, BUSY=0, then IDLE.
- Word latency: 1 ARM + REG_BITS SHIFT + 1 EMIT + 1 NEXT = REG_BITS+3 cycles with DATA_READY held high.
- Order: channel ascending (outer loop), register ascending (inner loop). Masked channels cost zero cycles.
- ABORT (any non-IDLE state): next cycle INST_READOUT=0, DATA_VALID=0, go to FIN (DONE pulse). A word pending in EMIT is discarded. ABORT in IDLE has no effect.
- Simultaneous ABORT and DATA_READY in EMIT: abort wins; the word is not counted as transferred.
- CH_MASK changes during a scan have no effect (mask_q only).
- Reset mid-scan: immediate return to IDLE; INST_READOUT deasserts asynchronously.

Test Plan:
- Full scan: CH_MASK=8'hFF, DATA_READY=1, each channel serializes 10'h3A5^{ch,reg} → 48 words in ch0r0..ch7r5 order, values match, INST_READOUT low exactly once between words, DONE 48×13+1 cycles after request.
- Sparse mask: CH_MASK=8'b1000_0010 → only ch1 then ch7, 12 words, DATA_CH tags 1 and 7 only; CH_MASK=0 → DONE on cycle 2, zero DATA_VALID.
- Backpressure: DATA_READY low for 20 cycles on word 3 → DATA_OUT/tags stable, INST_READOUT=0 throughout, no SHIFT activity; scan resumes correctly.
- Abort: ABORT asserted in SHIFT of ch2r4 → INST_READOUT=0 next cycle, single DONE, BUSY low; new READOUT_REQ restarts from first enabled channel, reg 0.
- Reset/ignore: READOUT_REQ pulse while BUSY → no restart; RSTB low mid-EMIT → all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/ch_readout_sequencer.sv
// Slow-readout scheduler: walks enabled channels and their registers, deserializes
// each channel's CNT_SER stream and hands words to the SPI buffer over valid/ready.
module ch_readout_sequencer #(
  parameter int NUM_CH   = 8,
  parameter int NUM_REG  = 6,
  parameter int REG_BITS = 10
) (
  input  logic                      SPI_CLK,
  input  logic                      RSTB,
  input  logic                      READOUT_REQ,
  input  logic                      ABORT,
  input  logic [NUM_CH-1:0]         CH_MASK,
  input  logic [NUM_CH-1:0]         CNT_SER_IN,
  input  logic                      DATA_READY,
  output logic                      INST_READOUT,
  output logic [2:0]                SELECT_REG,
  output logic [$clog2(NUM_CH)-1:0] CH_SEL,
  output logic [REG_BITS-1:0]       DATA_OUT,
  output logic [$clog2(NUM_CH)-1:0] DATA_CH,
  output logic [2:0]                DATA_REG,
  output logic                      DATA_VALID,
  output logic                      BUSY,
  output logic                      DONE
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(REG_BITS + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_SHIFT, S_EMIT, S_NEXT, S_FIN} state_t;

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [2:0]          reg_q, reg_d;
  logic [REG_BITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [CH_W:0]       first_ch, next_ch;

  // Lowest set bit of m at index lo or above; the MSB of the result flags a hit.
  function automatic logic [CH_W:0] find_set(input logic [NUM_CH-1:0] m, input int lo);
    logic [CH_W:0] res;
    res = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && (i >= lo)) res = {1'b1, CH_W'(i)};
    end
    return res;
  endfunction

  assign first_ch = find_set(CH_MASK, 0);
  assign next_ch  = find_set(mask_q, int'(ch_q) + 1);

  always_ff @(posedge SPI_CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q  <= S_IDLE;
      mask_q   <= '0;
      ch_q     <= '0;
      reg_q    <= '0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      ch_q     <= ch_d;
      reg_q    <= reg_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    ch_d     = ch_q;
    reg_d    = reg_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (READOUT_REQ) begin
          mask_d  = CH_MASK;
          ch_d    = first_ch[CH_W-1:0];
          reg_d   = '0;
          state_d = first_ch[CH_W] ? S_ARM : S_FIN;
        end
      end
      S_ARM: begin
        shreg_d  = '0;
        bitcnt_d = '0;
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        shreg_d  = {shreg_q[REG_BITS-2:0], CNT_SER_IN[ch_q]};
        bitcnt_d = bitcnt_q + 1'b1;
        if (bitcnt_q == CNT_W'(REG_BITS - 1)) state_d = S_EMIT;
      end
      S_EMIT: begin
        if (DATA_READY) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (int'(reg_q) < NUM_REG - 1) begin
          reg_d   = reg_q + 3'd1;
          state_d = S_ARM;
        end else begin
          reg_d = '0;
          if (next_ch[CH_W]) begin
            ch_d    = next_ch[CH_W-1:0];
            state_d = S_ARM;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides any handshake in the same cycle; a pending word is dropped.
    if (ABORT && (state_q inside {S_ARM, S_SHIFT, S_EMIT, S_NEXT})) state_d = S_FIN;
  end

  assign INST_READOUT = (state_q == S_ARM) || (state_q == S_SHIFT);
  assign SELECT_REG   = reg_q;
  assign CH_SEL       = ch_q;
  assign DATA_OUT     = shreg_q;
  assign DATA_CH      = ch_q;
  assign DATA_REG     = reg_q;
  assign DATA_VALID   = (state_q == S_EMIT);
  assign BUSY         = state_q inside {S_ARM, S_SHIFT, S_EMIT, S_NEXT};
  assign DONE         = (state_q == S_FIN);

endmodule

// File: tb/tb_ch_readout_sequencer.sv
// Bench for ch_readout_sequencer: channel serializer model plus a word-list
// reference built from the mask, checked per scenario.
module tb_ch_readout_sequencer;
  localparam int NUM_CH   = 8;
  localparam int NUM_REG  = 6;
  localparam int REG_BITS = 10;

  logic        SPI_CLK = 1'b0;
  logic        RSTB = 1'b0;
  logic        READOUT_REQ = 1'b0;
  logic        ABORT = 1'b0;
  logic        DATA_READY = 1'b0;
  logic [7:0]  CH_MASK = '0;
  logic [7:0]  CNT_SER_IN = '0;
  logic        INST_READOUT;
  logic [2:0]  SELECT_REG;
  logic [2:0]  CH_SEL;
  logic [9:0]  DATA_OUT;
  logic [2:0]  DATA_CH;
  logic [2:0]  DATA_REG;
  logic        DATA_VALID;
  logic        BUSY;
  logic        DONE;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int req_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int falls = 0;
  int valid_cyc = 0;
  int hi_cnt = 0;
  logic prev_inst = 1'b0;
  logic [9:0]  base = 10'h3A5;
  logic [15:0] got[$];
  logic [15:0] exp_q[$];

  ch_readout_sequencer #(.NUM_CH(NUM_CH), .NUM_REG(NUM_REG), .REG_BITS(REG_BITS)) dut (
    .SPI_CLK(SPI_CLK), .RSTB(RSTB), .READOUT_REQ(READOUT_REQ), .ABORT(ABORT),
    .CH_MASK(CH_MASK), .CNT_SER_IN(CNT_SER_IN), .DATA_READY(DATA_READY),
    .INST_READOUT(INST_READOUT), .SELECT_REG(SELECT_REG), .CH_SEL(CH_SEL),
    .DATA_OUT(DATA_OUT), .DATA_CH(DATA_CH), .DATA_REG(DATA_REG),
    .DATA_VALID(DATA_VALID), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 SPI_CLK = ~SPI_CLK;

  function automatic logic [9:0] word_of(input int c, input int r);
    return base ^ 10'(c * 8 + r);
  endfunction

  // Channel model: loads its word while INST_READOUT is first high, then presents
  // it MSB first, one bit per following cycle; junk bits otherwise.
  always @(negedge SPI_CLK) begin
    if (!RSTB || !INST_READOUT) hi_cnt = 0;
    else hi_cnt = hi_cnt + 1;
    for (int c = 0; c < NUM_CH; c++) begin
      logic [9:0] w;
      w = word_of(c, int'(SELECT_REG));
      if (hi_cnt >= 2 && hi_cnt <= REG_BITS + 1) CNT_SER_IN[c] = w[REG_BITS + 1 - hi_cnt];
      else CNT_SER_IN[c] = 1'($urandom);
    end
  end

  // Per-cycle observer, sampled mid low phase after inputs have settled.
  always @(negedge SPI_CLK) begin
    #2;
    cyc = cyc + 1;
    if (READOUT_REQ && !BUSY && !DONE && RSTB) req_cyc = cyc;
    if (RSTB && DATA_VALID && DATA_READY && !ABORT) got.push_back({DATA_CH, DATA_REG, DATA_OUT});
    if (DATA_VALID) valid_cyc = valid_cyc + 1;
    if (DONE) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (prev_inst && !INST_READOUT) falls = falls + 1;
    prev_inst = INST_READOUT;
  end

  task automatic build_exp(input logic [7:0] m);
    exp_q.delete();
    for (int c = 0; c < NUM_CH; c++)
      if (m[c])
        for (int r = 0; r < NUM_REG; r++) exp_q.push_back({3'(c), 3'(r), word_of(c, r)});
  endtask

  task automatic start_req(input logic [7:0] m);
    @(negedge SPI_CLK);
    CH_MASK = m;
    READOUT_REQ = 1'b1;
    @(negedge SPI_CLK);
    READOUT_REQ = 1'b0;
  endtask

  task automatic wait_done(input int limit, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (DONE) begin
        ok = 1'b1;
        break;
      end
      @(negedge SPI_CLK);
      if (rnd) begin
        DATA_READY = ($urandom_range(3) != 0);
        CH_MASK = 8'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    logic [25:0] outs;
    repeat (3) @(negedge SPI_CLK);
    outs = {INST_READOUT, SELECT_REG, CH_SEL, DATA_OUT, DATA_CH, DATA_REG, DATA_VALID, BUSY, DONE};
    checks++;
    if (outs !== 26'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", outs); end
    RSTB = 1'b1;
    repeat (2) @(negedge SPI_CLK);
    outs = {INST_READOUT, SELECT_REG, CH_SEL, DATA_OUT, DATA_CH, DATA_REG, DATA_VALID, BUSY, DONE};
    checks++;
    if (outs !== 26'd0) begin failures++; $display("FAIL idle_outputs got=%h exp=0", outs); end
  endtask

  task automatic test_full_scan();
    int g0, f0, d0;
    bit ok;
    base = 10'h3A5;
    DATA_READY = 1'b1;
    build_exp(8'hFF);
    g0 = got.size(); f0 = falls; d0 = done_cnt;
    start_req(8'hFF);
    wait_done(800, 1'b0, ok);
    @(negedge SPI_CLK);
    checks++;
    if (!ok) begin failures++; $display("FAIL full_done_timeout got=none exp=DONE within 800"); end
    checks++;
    if (got.size() - g0 !== 48) begin failures++; $display("FAIL full_count got=%0d exp=48", got.size() - g0); end
    for (int i = 0; i < exp_q.size() && g0 + i < got.size(); i++) begin
      checks++;
      if (got[g0+i] !== exp_q[i]) begin failures++; $display("FAIL full_word[%0d] got=%h exp=%h", i, got[g0+i], exp_q[i]); end
    end
    checks++;
    if (done_cyc - req_cyc !== 48*13+1) begin failures++; $display("FAIL full_latency got=%0d exp=%0d", done_cyc - req_cyc, 48*13+1); end
    checks++;
    if (falls - f0 !== 48) begin failures++; $display("FAIL full_inst_falls got=%0d exp=48", falls - f0); end
    checks++;
    if (done_cnt - d0 !== 1 || BUSY !== 1'b0) begin
      failures++; $display("FAIL full_done_once got=%0d busy=%b exp=1 busy=0", done_cnt - d0, BUSY);
    end
  endtask

  task automatic test_sparse();
    int g0, d0, v0;
    bit ok;
    base = 10'($urandom);
    DATA_READY = 1'b1;
    build_exp(8'b1000_0010);
    g0 = got.size();
    start_req(8'b1000_0010);
    wait_done(400, 1'b0, ok);
    @(negedge SPI_CLK);
    checks++;
    if (!ok || got.size() - g0 !== 12) begin failures++; $display("FAIL sparse_count got=%0d exp=12 done=%b", got.size() - g0, ok); end
    for (int i = 0; i < exp_q.size() && g0 + i < got.size(); i++) begin
      checks++;
      if (got[g0+i] !== exp_q[i]) begin failures++; $display("FAIL sparse_word[%0d] got=%h exp=%h", i, got[g0+i], exp_q[i]); end
    end
    checks++;
    if (done_cyc - req_cyc !== 12*13+1) begin failures++; $display("FAIL sparse_latency got=%0d exp=%0d", done_cyc - req_cyc, 12*13+1); end
    g0 = got.size(); d0 = done_cnt; v0 = valid_cyc;
    start_req(8'h00);
    wait_done(10, 1'b0, ok);
    @(negedge SPI_CLK);
    checks++;
    if (!ok || done_cyc - req_cyc !== 1) begin failures++; $display("FAIL empty_latency got=%0d exp=1 done=%b", done_cyc - req_cyc, ok); end
    checks++;
    if (valid_cyc - v0 !== 0 || done_cnt - d0 !== 1) begin
      failures++; $display("FAIL empty_no_data valid=%0d done=%0d exp valid=0 done=1", valid_cyc - v0, done_cnt - d0);
    end
  endtask

  task automatic test_backpressure();
    int g0, bad;
    bit ok, seen;
    logic [15:0] snap;
    base = 10'($urandom);
    DATA_READY = 1'b1;
    build_exp(8'h05);
    g0 = got.size();
    start_req(8'h05);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (got.size() - g0 == 3) begin seen = 1'b1; break; end
      @(negedge SPI_CLK);
    end
    DATA_READY = 1'b0;
    for (int i = 0; i < 30 && seen; i++) begin
      if (DATA_VALID) break;
      @(negedge SPI_CLK);
    end
    checks++;
    if (!seen || !DATA_VALID) begin failures++; $display("FAIL bp_reach_word3 got=valid %b exp=1", DATA_VALID); end
    snap = {DATA_CH, DATA_REG, DATA_OUT};
    checks++;
    if (snap !== exp_q[3]) begin failures++; $display("FAIL bp_word3 got=%h exp=%h", snap, exp_q[3]); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge SPI_CLK);
      if (DATA_VALID !== 1'b1 || INST_READOUT !== 1'b0 || {DATA_CH, DATA_REG, DATA_OUT} !== snap) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL bp_stable got=%0d unstable cycles exp=0", bad); end
    @(negedge SPI_CLK);
    DATA_READY = 1'b1;
    wait_done(400, 1'b0, ok);
    @(negedge SPI_CLK);
    checks++;
    if (!ok || got.size() - g0 !== 12) begin failures++; $display("FAIL bp_count got=%0d exp=12 done=%b", got.size() - g0, ok); end
    for (int i = 0; i < exp_q.size() && g0 + i < got.size(); i++) begin
      checks++;
      if (got[g0+i] !== exp_q[i]) begin failures++; $display("FAIL bp_word[%0d] got=%h exp=%h", i, got[g0+i], exp_q[i]); end
    end
    checks++;
    if (done_cyc - req_cyc !== 12*13+1+20) begin failures++; $display("FAIL bp_latency got=%0d exp=%0d", done_cyc - req_cyc, 12*13+21); end
  endtask

  task automatic test_abort();
    int g0, d0;
    bit ok, seen;
    base = 10'($urandom);
    DATA_READY = 1'b1;
    build_exp(8'h26);
    g0 = got.size(); d0 = done_cnt;
    start_req(8'h26);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (INST_READOUT && CH_SEL == 3'd2 && SELECT_REG == 3'd4) begin seen = 1'b1; break; end
      @(negedge SPI_CLK);
    end
    repeat (3) @(negedge SPI_CLK);
    ABORT = 1'b1;
    @(negedge SPI_CLK);
    ABORT = 1'b0;
    checks++;
    if (!seen || INST_READOUT !== 1'b0 || DATA_VALID !== 1'b0 || DONE !== 1'b1 || BUSY !== 1'b0) begin
      failures++; $display("FAIL abort_response got=inst%b vld%b done%b busy%b exp=inst0 vld0 done1 busy0", INST_READOUT, DATA_VALID, DONE, BUSY);
    end
    @(negedge SPI_CLK);
    checks++;
    if (DONE !== 1'b0 || done_cnt - d0 !== 1) begin failures++; $display("FAIL abort_single_done got=%0d exp=1", done_cnt - d0); end
    checks++;
    if (got.size() - g0 !== 10) begin failures++; $display("FAIL abort_count got=%0d exp=10", got.size() - g0); end
    for (int i = 0; i < 10 && g0 + i < got.size(); i++) begin
      checks++;
      if (got[g0+i] !== exp_q[i]) begin failures++; $display("FAIL abort_word[%0d] got=%h exp=%h", i, got[g0+i], exp_q[i]); end
    end
    g0 = got.size();
    start_req(8'h26);
    wait_done(400, 1'b0, ok);
    @(negedge SPI_CLK);
    checks++;
    if (!ok || got.size() - g0 !== 18) begin failures++; $display("FAIL restart_count got=%0d exp=18 done=%b", got.size() - g0, ok); end
    for (int i = 0; i < exp_q.size() && g0 + i < got.size(); i++) begin
      checks++;
      if (got[g0+i] !== exp_q[i]) begin failures++; $display("FAIL restart_word[%0d] got=%h exp=%h", i, got[g0+i], exp_q[i]); end
    end
    // Abort coinciding with a handshake in EMIT.
    DATA_READY = 1'b0;
    start_req(8'h10 | 8'($urandom));
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (DATA_VALID) begin seen = 1'b1; break; end
      @(negedge SPI_CLK);
    end
    ABORT = 1'b1;
    DATA_READY = 1'b1;
    @(negedge SPI_CLK);
    ABORT = 1'b0;
    DATA_READY = 1'b0;
    checks++;
    if (!seen || DONE !== 1'b1 || BUSY !== 1'b0 || DATA_VALID !== 1'b0) begin
      failures++; $display("FAIL abort_beats_ready got=done%b busy%b vld%b exp=done1 busy0 vld0", DONE, BUSY, DATA_VALID);
    end
    @(negedge SPI_CLK);
    ABORT = 1'b1;
    @(negedge SPI_CLK);
    ABORT = 1'b0;
    checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b0) begin failures++; $display("FAIL abort_idle got=done%b busy%b exp=done0 busy0", DONE, BUSY); end
  endtask

  task automatic test_req_while_busy();
    int g0, d0;
    bit ok;
    base = 10'($urandom);
    DATA_READY = 1'b1;
    build_exp(8'h11);
    g0 = got.size(); d0 = done_cnt;
    start_req(8'h11);
    repeat (30) @(negedge SPI_CLK);
    CH_MASK = 8'hFF;
    READOUT_REQ = 1'b1;
    @(negedge SPI_CLK);
    READOUT_REQ = 1'b0;
    wait_done(400, 1'b0, ok);
    @(negedge SPI_CLK);
    checks++;
    if (!ok || got.size() - g0 !== 12) begin failures++; $display("FAIL busy_req_count got=%0d exp=12 done=%b", got.size() - g0, ok); end
    for (int i = 0; i < exp_q.size() && g0 + i < got.size(); i++) begin
      checks++;
      if (got[g0+i] !== exp_q[i]) begin failures++; $display("FAIL busy_req_word[%0d] got=%h exp=%h", i, got[g0+i], exp_q[i]); end
    end
    checks++;
    if (done_cyc - req_cyc !== 12*13+1 || done_cnt - d0 !== 1) begin
      failures++; $display("FAIL busy_req_latency got=%0d dones=%0d exp=%0d dones=1", done_cyc - req_cyc, done_cnt - d0, 12*13+1);
    end
  endtask

  task automatic test_reset_mid();
    int g0;
    bit ok, seen;
    logic [25:0] outs;
    base = 10'($urandom);
    DATA_READY = 1'b0;
    start_req(8'h08);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (DATA_VALID) begin seen = 1'b1; break; end
      @(negedge SPI_CLK);
    end
    #3 RSTB = 1'b0;
    #1 outs = {INST_READOUT, SELECT_REG, CH_SEL, DATA_OUT, DATA_CH, DATA_REG, DATA_VALID, BUSY, DONE};
    checks++;
    if (!seen || outs !== 26'd0) begin failures++; $display("FAIL reset_mid_async got=%h exp=0 reached_emit=%b", outs, seen); end
    @(negedge SPI_CLK);
    RSTB = 1'b1;
    repeat (2) @(negedge SPI_CLK);
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || DATA_VALID !== 1'b0 || INST_READOUT !== 1'b0) begin
      failures++; $display("FAIL reset_mid_idle got=busy%b done%b vld%b inst%b exp=all0", BUSY, DONE, DATA_VALID, INST_READOUT);
    end
    DATA_READY = 1'b1;
    build_exp(8'h08);
    g0 = got.size();
    start_req(8'h08);
    wait_done(200, 1'b0, ok);
    @(negedge SPI_CLK);
    checks++;
    if (!ok || got.size() - g0 !== 6) begin failures++; $display("FAIL reset_mid_rescan got=%0d exp=6 done=%b", got.size() - g0, ok); end
    for (int i = 0; i < exp_q.size() && g0 + i < got.size(); i++) begin
      checks++;
      if (got[g0+i] !== exp_q[i]) begin failures++; $display("FAIL reset_mid_word[%0d] got=%h exp=%h", i, got[g0+i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int g0, d0;
    bit ok;
    logic [7:0] m;
    for (int n = 0; n < 4; n++) begin
      m = 8'($urandom);
      base = 10'($urandom);
      build_exp(m);
      g0 = got.size(); d0 = done_cnt;
      start_req(m);
      wait_done(3000, 1'b1, ok);
      @(negedge SPI_CLK);
      DATA_READY = 1'b0;
      checks++;
      if (!ok || got.size() - g0 !== exp_q.size() || done_cnt - d0 !== 1) begin
        failures++; $display("FAIL rand_count mask=%h got=%0d exp=%0d done=%b", m, got.size() - g0, exp_q.size(), ok);
      end
      for (int i = 0; i < exp_q.size() && g0 + i < got.size(); i++) begin
        checks++;
        if (got[g0+i] !== exp_q[i]) begin failures++; $display("FAIL rand_word[%0d] mask=%h got=%h exp=%h", i, m, got[g0+i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_sparse();
    test_backpressure();
    test_abort();
    test_req_while_busy();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
